// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame shape.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DBIT    = 8;
  localparam int UART_SB_TICK = 16;

  // Start and data bits are always 16 oversampling ticks long.
  localparam logic [3:0] TICK_LAST = 4'd15;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-requester round-robin grant; on contention the source not served last wins.
module rr_arb2 (
  input  logic valid_a,
  input  logic valid_b,
  input  logic last_src,
  output logic grant_a,
  output logic grant_b
);

  assign grant_a = valid_a & (~valid_b | last_src);
  assign grant_b = valid_b & (~valid_a | ~last_src);

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmitter shared by two byte requesters under round-robin arbitration.
// state | meaning: IDLE line high, grant | START start bit | DATA LSB-first bits | STOP stop bit
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic [DBIT-1:0] i_data_a,
  input  logic [DBIT-1:0] i_data_b,
  input  logic            i_valid_a,
  input  logic            i_valid_b,
  output logic            o_ready_a,
  output logic            o_ready_b,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_src
);

  localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

  uart_state_e     state, state_next;
  logic [3:0]      tick_cnt, tick_next;
  logic [2:0]      bit_cnt, bit_next;
  logic [DBIT-1:0] shreg, shreg_next, shreg_shift;
  logic            tx_next, done_next, src_next;
  logic            last_src, last_next;
  logic            grant_a, grant_b;

  rr_arb2 u_arb (
    .valid_a  (i_valid_a),
    .valid_b  (i_valid_b),
    .last_src (last_src),
    .grant_a  (grant_a),
    .grant_b  (grant_b)
  );

  assign shreg_shift = shreg >> 1;
  assign o_busy      = (state != ST_IDLE);

  // last_src resets to B so that A wins the first contention.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
      o_src    <= 1'b0;
      last_src <= 1'b1;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      o_tx     <= tx_next;
      o_done   <= done_next;
      o_src    <= src_next;
      last_src <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    tx_next    = o_tx;
    done_next  = 1'b0;
    src_next   = o_src;
    last_next  = last_src;
    o_ready_a  = 1'b0;
    o_ready_b  = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_next   = 1'b1;
        o_ready_a = grant_a & ~i_reset;
        o_ready_b = grant_b & ~i_reset;
        // A tick coinciding with the accept is dropped by clearing the counter.
        if (grant_a | grant_b) begin
          shreg_next = grant_b ? i_data_b : i_data_a;
          src_next   = grant_b;
          last_next  = grant_b;
          tick_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b0;
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next  = '0;
            tx_next    = shreg[0];
            state_next = ST_DATA;
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next  = '0;
            shreg_next = shreg_shift;
            if (bit_cnt == BIT_LAST) begin
              tx_next    = 1'b1;
              state_next = ST_STOP;
            end else begin
              bit_next = bit_cnt + 3'd1;
              tx_next  = shreg_shift[0];
            end
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end
      end

      ST_STOP: begin
        tx_next = 1'b1;
        if (i_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_next  = '0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule
